pipelined_adder: RTL

//   Parametrised, pipelined N-bit add/subtract unit; next generation of the 1-bit half adder.

---
 rtl/pipelined_adder_pkg.sv | 13 +
 rtl/pipelined_adder_if.sv | 30 +++
 rtl/adder_slice.sv | 30 +++
 rtl/pipelined_adder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encodings
// and the parameter legality check used at elaboration.
package pipelined_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The carry chain is cut into equal segments, so the width must split evenly.
  function automatic bit stagesDivideWidth(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder with valid/ready on both sides.
// The slave modport is the adder itself; the master drives operands and takes results.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/adder_slice.sv
// One combinational carry segment: SEG-bit ripple adder built from a pair of
// half-adder cells per bit (together forming a full adder).
module adder_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  // Carry is kept in a block-local variable so the chain is a single expression
  // walk rather than a self-referencing vector.
  always_comb begin
    logic carry;
    logic halfSum;
    logic halfCarry;
    s     = '0;
    carry = ci;
    for (int i = 0; i < SEG; i++) begin
      halfSum   = a[i] ^ b[i];
      halfCarry = a[i] & b[i];
      s[i]      = halfSum ^ carry;
      carry     = halfCarry | (halfSum & carry);
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with one register boundary per carry segment,
// valid/ready handshake on both sides, and registered carry/overflow/zero flags.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;

  if (!stagesDivideWidth(WIDTH, STAGES)) begin : g_badParams
    $error("pipelined_adder: WIDTH must be >= 1 and an exact multiple of STAGES");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_bEff;
  logic             w_carryIn;

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_acc   [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_carry [STAGES];
  logic             r_aMsb  [STAGES];
  logic             r_bMsb  [STAGES];
  logic             r_ovf;
  logic             r_zero;

  logic             w_inValid [STAGES];
  logic [WIDTH-1:0] w_inAcc   [STAGES];
  logic [WIDTH-1:0] w_inB     [STAGES];
  logic             w_inCarry [STAGES];
  logic             w_inAMsb  [STAGES];
  logic             w_inBMsb  [STAGES];
  logic [SEG-1:0]   w_segS    [STAGES];
  logic             w_segCo   [STAGES];
  logic [WIDTH-1:0] w_nextAcc [STAGES];
  logic [WIDTH-1:0] w_sumNext;
  logic             w_ovfNext;
  logic             w_zeroNext;

  assign w_bEff    = (bus.sub == OP_ADD) ? bus.b : ~bus.b;
  assign w_carryIn = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

  // r_acc holds finished low sum segments below the still-unprocessed upper bits of a,
  // so one vector per stage carries both the skewed operand and the deskewed result.
  always_comb begin
    w_inValid[0] = bus.in_valid;
    w_inAcc[0]   = bus.a;
    w_inB[0]     = w_bEff;
    w_inCarry[0] = w_carryIn;
    w_inAMsb[0]  = bus.a[WIDTH-1];
    w_inBMsb[0]  = w_bEff[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      w_inValid[k] = r_valid[k-1];
      w_inAcc[k]   = r_acc[k-1];
      w_inB[k]     = r_b[k-1];
      w_inCarry[k] = r_carry[k-1];
      w_inAMsb[k]  = r_aMsb[k-1];
      w_inBMsb[k]  = r_bMsb[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SEG(SEG)) u_slice (
      .a  (w_inAcc[k][k*SEG +: SEG]),
      .b  (w_inB[k][k*SEG +: SEG]),
      .ci (w_inCarry[k]),
      .s  (w_segS[k]),
      .co (w_segCo[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nextAcc[k]                = w_inAcc[k];
      w_nextAcc[k][k*SEG +: SEG]  = w_segS[k];
    end
  end

  assign w_sumNext  = w_nextAcc[STAGES-1];
  assign w_ovfNext  = (w_inAMsb[STAGES-1] ~^ w_inBMsb[STAGES-1])
                    & (w_sumNext[WIDTH-1] ^ w_inAMsb[STAGES-1]);
  assign w_zeroNext = ~|w_sumNext;

  // Valid bits shift on every advance so bubbles travel with the data; payload only
  // loads for real ops, which keeps the result and flags steady across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_acc[k]   <= '0;
        r_b[k]     <= '0;
        r_carry[k] <= 1'b0;
        r_aMsb[k]  <= 1'b0;
        r_bMsb[k]  <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_inValid[k];
        if (w_inValid[k]) begin
          r_acc[k]   <= w_nextAcc[k];
          r_b[k]     <= w_inB[k];
          r_carry[k] <= w_segCo[k];
          r_aMsb[k]  <= w_inAMsb[k];
          r_bMsb[k]  <= w_inBMsb[k];
        end
      end
      if (w_inValid[STAGES-1]) begin
        r_ovf  <= w_ovfNext;
        r_zero <= w_zeroNext;
      end
    end
  end

  assign w_advance     = ~r_valid[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_acc[STAGES-1];
  assign bus.cout      = r_carry[STAGES-1];
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
